cla_addsub_seq: RTL and testbench

- Iterative WIDTH-bit adder/subtractor. Processes one CHUNK-bit slice per clock through a single carry-lookahead slice, holding the inter-slice carry in a register.
- Trades latency for area against the fully parallel lookahead tree. It is the sequential datapath in the 64-bit arithmetic unit.
- Valid/ready handshake on both the operand and result sides.

---
 rtl/cla_seq_pkg.sv | 16 +
 rtl/cla_slice.sv | 44 ++++
 rtl/cla_addsub_seq.sv | 128 ++++++++++++
 tb/tb_cla_addsub_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the iterative carry-lookahead adder/subtractor.
// Holds the FSM state enum, op encoding and the default slice width.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int CHUNK_DEF = 16;

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK-bit carry-lookahead slice.
// Ports: a, b, cin -> sum, cout, pg (group propagate), gg (group generate).
module cla_slice
#(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             pg,
    output logic             gg
);

    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK:0]   c;
    logic             gacc;
    logic             pacc;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is formed from the prefix group terms
    // G[i:0] | P[i:0]&cin rather than from the previous carry.
    always_comb begin
        gacc = 1'b0;
        pacc = 1'b1;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            gacc     = g[i] | (p[i] & gacc);
            pacc     = p[i] & pacc;
            c[i + 1] = gacc | (pacc & cin);
        end
    end

    assign sum  = p ^ c[CHUNK-1:0];
    assign cout = c[CHUNK];
    assign pg   = pacc;
    assign gg   = gacc;

endmodule

// File: rtl/cla_addsub_seq.sv
// Iterative WIDTH-bit add/sub: one CHUNK slice per clock, carry held in a register.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, op (0 add, 1 sub);
//   out_valid/out_ready, result, carry_out (sub: 1 = no borrow), overflow, zero.
// Macro CLA_SEQ_FLAGS_EN enables overflow/zero; otherwise both are tied to 0.
module cla_addsub_seq
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = CHUNK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cy;

    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic [CHUNK-1:0] s_s;
    logic             c_s;
    logic             pg_unused;
    logic             gg_unused;

    assign in_ready = (state == IDLE);

    assign a_s = a_q[idx*CHUNK +: CHUNK];
    assign b_s = b_q[idx*CHUNK +: CHUNK];

    cla_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a    (a_s),
        .b    (b_s),
        .cin  (cy),
        .sum  (s_s),
        .cout (c_s),
        .pg   (pg_unused),
        .gg   (gg_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cy        <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        // Subtract is a + ~b + 1: invert b, seed carry with op.
                        b_q   <= (op == OP_SUB) ? ~b : b;
                        cy    <= op;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    result[idx*CHUNK +: CHUNK] <= s_s;
                    cy  <= c_s;
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        carry_out <= c_s;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLA_SEQ_FLAGS_EN
    logic zacc;

    // zacc is the AND of the slice-zero terms written so far.
    always_ff @(posedge clk) begin
        if (rst) begin
            zacc     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            zacc <= 1'b1;
        end else if (state == RUN) begin
            zacc <= zacc & ~|s_s;
            if (idx == LAST) begin
                zero     <= zacc & ~|s_s;
                overflow <= (a_s[CHUNK-1] == b_s[CHUNK-1])
                         && (s_s[CHUNK-1] != a_s[CHUNK-1]);
            end
        end
    end
`else
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_cla_addsub_seq.sv
// Directed-vector bench for cla_addsub_seq (64-bit, 16-bit slices).
// Flag expectations follow CLA_SEQ_FLAGS_EN; without it both flags must stay 0.
module tb_cla_addsub_seq;

    localparam int W = 64;

`ifdef CLA_SEQ_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int n_tests = 0;
    int n_fail  = 0;

    cla_addsub_seq #(
        .WIDTH (W),
        .CHUNK (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait (bounded) for out_valid and return the latency.
    task automatic issue(input logic [W-1:0] va,
                         input logic [W-1:0] vb,
                         input logic vop,
                         output int lat);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        in_valid = 1'b1;
        a = va;
        b = vb;
        op = vop;
        tick();
        in_valid = 1'b0;
        // Scribble operands during RUN; they must be ignored.
        a = ~va;
        b = ~vb;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag,
                          input logic [W-1:0] va,
                          input logic [W-1:0] vb,
                          input logic vop,
                          input logic [W-1:0] er,
                          input logic ec,
                          input logic eov,
                          input logic ez);
        int lat;
        issue(va, vb, vop, lat);
        chk({tag, ".lat"}, 64'(lat), 64'd4);
        chk({tag, ".res"}, result, er);
        chk({tag, ".cy"}, 64'(carry_out), 64'(ec));
        chk({tag, ".ov"}, 64'(overflow), 64'(eov & FL));
        chk({tag, ".z"}, 64'(zero), 64'(ez & FL));
        chk({tag, ".rdy"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".ovld"}, 64'(out_valid), 64'd0);
        chk({tag, ".irdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst.ovld", 64'(out_valid), 64'd0);
        chk("rst.irdy", 64'(in_ready), 64'd1);
        chk("rst.res", result, 64'd0);
        chk("rst.cy", 64'(carry_out), 64'd0);
        chk("rst.ov", 64'(overflow), 64'd0);
        chk("rst.z", 64'(zero), 64'd0);

        // out_ready while idle is a no-op
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("idle.ovld", 64'(out_valid), 64'd0);
        chk("idle.irdy", 64'(in_ready), 64'd1);

        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'd0, 1'b1, 1'b0, 1'b1);
        run_op("xcy", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
               64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0);
        run_op("borrow", 64'd5, 64'd7, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_op("subov", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_op("subz", 64'h1234_5678_9ABC_DEF0,
               64'h1234_5678_9ABC_DEF0, 1'b1,
               64'd0, 1'b1, 1'b0, 1'b1);
        run_op("mix", 64'h0123_4567_89AB_CDEF,
               64'h1111_2222_3333_4444, 1'b0,
               64'h1234_6789_BCDF_1233, 1'b0, 1'b0, 1'b0);

        // Backpressure: hold the result while inputs churn.
        issue(64'd1, 64'd2, 1'b0, lat);
        chk("bp.lat", 64'(lat), 64'd4);
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            a = 64'hDEAD_0000 + 64'(i);
            b = 64'hBEEF_0000 + 64'(i);
            op = i[0];
            tick();
            chk("bp.res", result, 64'd3);
            chk("bp.ovld", 64'(out_valid), 64'd1);
            chk("bp.irdy", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp.rel.ovld", 64'(out_valid), 64'd0);
        chk("bp.rel.irdy", 64'(in_ready), 64'd1);
        chk("bp.rel.res", result, 64'd3);

        // Reset while idx == 2
        in_valid = 1'b1;
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h1111_1111_1111_1111;
        op = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid.irdy", 64'(in_ready), 64'd0);
        chk("mid.part", result[31:0], 64'hABCD_F001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.ovld", 64'(out_valid), 64'd0);
        chk("mid.irdy2", 64'(in_ready), 64'd1);
        chk("mid.res", result, 64'd0);
        tick();
        chk("mid.hold", 64'(out_valid), 64'd0);

        run_op("after", 64'd3, 64'd1, 1'b1,
               64'd2, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
